// File: rtl/pipe_pkg.sv
// Shared pipeline constants used by the drain stage
// and its neighbours.
package pipe_pkg;

  localparam int PIPE_WIDTH = 8;
  localparam int DROP_CNT_W = 8;

  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

endpackage

// File: rtl/pipe_drain_fifo.sv
// Elastic drain stage behind the non-stallable pipeline:
// show-ahead FIFO, drops words when full and counts them.
module pipe_drain_fifo
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [DROP_CNT_W-1:0]      drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_chk_pow2
    $error("pipe_drain_fifo: DEPTH must be a power of two");
  end
  if (DEPTH < 2) begin : g_chk_min
    $error("pipe_drain_fifo: DEPTH must be at least 2");
  end

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [PW-1:0]         wr_q, wr_d;
  logic [PW-1:0]         rd_q, rd_d;
  logic                  ovf_q, ovf_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  logic empty, full, pop, push, drop;

  always_comb begin
    empty = (wr_q == rd_q);
    full  = (wr_q[AW-1:0] == rd_q[AW-1:0])
         && (wr_q[AW] != rd_q[AW]);
    pop   = !empty && out_ready;
    // A pop frees the slot this same edge, so a full
    // FIFO still accepts the incoming word.
    push  = in_valid && (!full || pop);
    drop  = in_valid && full && !pop;
  end

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (push) wr_d = wr_q + PW'(1);
    if (pop)  rd_d = rd_q + PW'(1);
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != DROP_CNT_MAX) drop_d = drop_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_q[AW-1:0]] <= in_data;
    end
  end

  assign out_valid = !empty;
  assign out_data  = mem_q[rd_q[AW-1:0]];
  assign count     = wr_q - rd_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_pipe_drain_fifo.sv
// Self-checking bench for pipe_drain_fifo: vector table,
// corner sequences and random traffic against a queue model.
module tb_pipe_drain_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [2:0] count;
  logic       overflow;
  logic [7:0] drop_cnt;

  pipe_drain_fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] mq[$];
  logic       m_ovf;
  int         m_drop;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_drop = 0;
  endtask

  task automatic cyc(input logic iv, input logic [7:0] d,
                     input logic rdy);
    in_valid = iv;
    in_data = d;
    out_ready = rdy;
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    if (iv) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, int'(out_valid), int'(mq.size() != 0));
    chk({tag, ".count"}, int'(count), mq.size());
    chk({tag, ".ovf"}, int'(overflow), int'(m_ovf));
    chk({tag, ".drop"}, int'(drop_cnt), m_drop);
    if (mq.size() != 0) chk({tag, ".data"}, int'(out_data), int'(mq[0]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       rdy;
    logic       e_val;
    logic [7:0] e_data;
    logic       e_dchk;
    int         e_cnt;
    logic       e_ovf;
    int         e_drop;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic iv, logic [7:0] d, logic rdy,
                              logic ev, logic [7:0] ed, logic edc,
                              int ec, logic eo, int edr);
    vec_t v;
    v.iv = iv; v.d = d; v.rdy = rdy;
    v.e_val = ev; v.e_data = ed; v.e_dchk = edc;
    v.e_cnt = ec; v.e_ovf = eo; v.e_drop = edr;
    return v;
  endfunction

  initial begin
    logic [7:0] nxt;
    logic [7:0] exp_d;
    int iv_i, rdy_i;

    // idle / out_ready on empty / 3-word burst then drain
    vt.push_back(mk(0, 8'h00, 1, 0, 8'h00, 1, 0, 0, 0));
    vt.push_back(mk(1, 8'h11, 0, 1, 8'h11, 1, 1, 0, 0));
    vt.push_back(mk(1, 8'h22, 0, 1, 8'h11, 1, 2, 0, 0));
    vt.push_back(mk(1, 8'h33, 0, 1, 8'h11, 1, 3, 0, 0));
    vt.push_back(mk(0, 8'h00, 1, 1, 8'h22, 1, 2, 0, 0));
    vt.push_back(mk(0, 8'h00, 1, 1, 8'h33, 1, 1, 0, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 8'h00, 1, 0, 0, 0));
    // fill, overflow twice, push while full and popping
    vt.push_back(mk(1, 8'hA0, 0, 1, 8'hA0, 1, 1, 0, 0));
    vt.push_back(mk(1, 8'hA1, 0, 1, 8'hA0, 1, 2, 0, 0));
    vt.push_back(mk(1, 8'hA2, 0, 1, 8'hA0, 1, 3, 0, 0));
    vt.push_back(mk(1, 8'hA3, 0, 1, 8'hA0, 1, 4, 0, 0));
    vt.push_back(mk(1, 8'hA4, 0, 1, 8'hA0, 1, 4, 1, 1));
    vt.push_back(mk(1, 8'hA5, 0, 1, 8'hA0, 1, 4, 1, 2));
    vt.push_back(mk(1, 8'hB0, 1, 1, 8'hA1, 1, 4, 1, 2));
    vt.push_back(mk(0, 8'h00, 1, 1, 8'hA2, 1, 3, 1, 2));
    vt.push_back(mk(0, 8'h00, 1, 1, 8'hA3, 1, 2, 1, 2));
    vt.push_back(mk(0, 8'h00, 1, 1, 8'hB0, 1, 1, 1, 2));
    vt.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 2));
    // empty + push + ready: push only, then hold stable
    vt.push_back(mk(1, 8'hC1, 1, 1, 8'hC1, 1, 1, 1, 2));
    vt.push_back(mk(0, 8'hFF, 0, 1, 8'hC1, 1, 1, 1, 2));
    vt.push_back(mk(0, 8'hEE, 0, 1, 8'hC1, 1, 1, 1, 2));
    vt.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 2));

    do_reset();
    chk("rst.valid", int'(out_valid), 0);
    chk("rst.data", int'(out_data), 0);
    chk("rst.count", int'(count), 0);
    chk("rst.ovf", int'(overflow), 0);
    chk("rst.drop", int'(drop_cnt), 0);

    for (int i = 0; i < vt.size(); i++) begin
      cyc(vt[i].iv, vt[i].d, vt[i].rdy);
      chk($sformatf("vec%0d.valid", i), int'(out_valid), int'(vt[i].e_val));
      chk($sformatf("vec%0d.count", i), int'(count), vt[i].e_cnt);
      chk($sformatf("vec%0d.ovf", i), int'(overflow), int'(vt[i].e_ovf));
      chk($sformatf("vec%0d.drop", i), int'(drop_cnt), vt[i].e_drop);
      if (vt[i].e_dchk)
        chk($sformatf("vec%0d.data", i), int'(out_data), int'(vt[i].e_data));
    end

    // streaming push+pop across several pointer wraps
    do_reset();
    cyc(1, 8'h40, 0);
    nxt = 8'h41;
    exp_d = 8'h40;
    for (int i = 0; i < 20; i++) begin
      chk("stream.head", int'(out_data), int'(exp_d));
      cyc(1, nxt, 1);
      nxt++;
      exp_d++;
      chk("stream.count", int'(count), 1);
    end
    chk_model("stream");

    // drop counter saturates at 255
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i), 0);
    for (int i = 0; i < 260; i++) cyc(1, 8'hDD, 0);
    chk("sat.drop", int'(drop_cnt), 255);
    chk("sat.count", int'(count), DEPTH);
    chk_model("sat");

    // async reset mid-stream with count 3 and overflow set
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 8'h70 + 8'(i), 0);
    cyc(0, 8'h00, 1);
    chk("pre_arst.count", int'(count), 3);
    chk("pre_arst.ovf", int'(overflow), 1);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst.valid", int'(out_valid), 0);
    chk("arst.data", int'(out_data), 0);
    chk("arst.count", int'(count), 0);
    chk("arst.ovf", int'(overflow), 0);
    chk("arst.drop", int'(drop_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1, 8'h5A, 0);
    chk("post_arst.data", int'(out_data), 8'h5A);
    chk_model("post_arst");

    // random traffic against the queue model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      iv_i = ($urandom_range(0, 99) < 60) ? 1 : 0;
      rdy_i = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35)) ? 1 : 0;
      cyc(iv_i[0], 8'($urandom), rdy_i[0]);
      chk_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
